// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state type and time constants for the stopwatch and its display modules
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, VIEW} state_t;
  localparam int CS_PER_SEC = 100;
  localparam int MAX_TIME_DFLT = 359999;
  localparam int CS_PER_MIN = 6000;
  localparam int CS_PER_10S = 1000;
  localparam int CS_PER_S = 100;
endpackage

// File: rtl/stopwatch_lap_if.sv
// stopwatch_lap_if: key inputs and display/status outputs of the stopwatch core
interface stopwatch_lap_if #(parameter int CNT_W = 19, parameter int IDX_W = 3);
  logic key2, key1, key0;
  logic [CNT_W-1:0] time_display, time_counter;
  logic counting, paused, viewing, lap_full, overflow;
  logic [IDX_W:0] lap_count;
  logic [IDX_W-1:0] lap_index;
  modport master(output key2, key1, key0, input time_display, time_counter, counting, paused, viewing, lap_count, lap_index, lap_full, overflow);
  modport slave(input key2, key1, key0, output time_display, time_counter, counting, paused, viewing, lap_count, lap_index, lap_full, overflow);
endinterface

// File: rtl/stopwatch_lap_key_pulse.sv
// key_pulse: 2-FF synchroniser plus falling-edge one-shot for an active-low key
module key_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);
  logic [2:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= 3'b111;
      pulse <= 1'b0;
    end else begin
      sh <= {sh[1:0], key_n};
      pulse <= sh[2] & ~sh[1];
    end
endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: centisecond stopwatch with start/pause, lap capture and lap browsing
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int CNT_W     = 19,
  parameter int MAX_TIME  = MAX_TIME_DFLT,
  parameter int LAP_DEPTH = 8,
  parameter int IDX_W     = $clog2(LAP_DEPTH)
) (
  input logic clk,
  input logic key3,
  stopwatch_lap_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  logic p2, p1, p0, s2, s1, s0, tick, full, ret_pause, ovf;
  state_t state;
  logic [PW-1:0] presc;
  logic [CNT_W-1:0] tc;
  logic [IDX_W:0] lap_count;
  logic [IDX_W-1:0] lap_index;
  logic [CNT_W-1:0] laps [LAP_DEPTH];
  key_pulse u_k2 (.clk(clk), .rst_n(key3), .key_n(bus.key2), .pulse(p2));
  key_pulse u_k1 (.clk(clk), .rst_n(key3), .key_n(bus.key1), .pulse(p1));
  key_pulse u_k0 (.clk(clk), .rst_n(key3), .key_n(bus.key0), .pulse(p0));
  assign s2 = p2;
  assign s1 = p1 & ~p2;
  assign s0 = p0 & ~p2 & ~p1;
  assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign full = lap_count == (IDX_W+1)'(LAP_DEPTH);
  always_ff @(posedge clk or negedge key3)
    if (!key3) begin
      state <= IDLE;
      ret_pause <= 1'b0;
      presc <= '0;
      tc <= '0;
      lap_count <= '0;
      lap_index <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == RUN) presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        tc <= (tc == CNT_W'(MAX_TIME)) ? '0 : tc + 1'b1;
        if (tc == CNT_W'(MAX_TIME)) ovf <= 1'b1;
      end
      case (state)
        IDLE:
          if (s2) begin
            state <= RUN;
            presc <= '0;
          end else if (s0 && lap_count != '0) begin
            state <= VIEW;
            lap_index <= '0;
            ret_pause <= 1'b0;
          end
        RUN:
          if (s2) state <= PAUSE;
          else if (s1 && !full) lap_count <= lap_count + 1'b1;
        PAUSE:
          if (s2) state <= RUN;
          else if (s0 && lap_count != '0) begin
            state <= VIEW;
            lap_index <= '0;
            ret_pause <= 1'b1;
          end
        VIEW:
          if (s2) state <= ret_pause ? PAUSE : IDLE;
          else if (s0) lap_index <= ({1'b0, lap_index} == lap_count - 1'b1) ? '0 : lap_index + 1'b1;
      endcase
    end
  // lap storage needs no reset; entries beyond lap_count are never shown
  always_ff @(posedge clk)
    if (state == RUN && s1 && !full) laps[lap_count[IDX_W-1:0]] <= tc;
  assign bus.time_counter = tc;
  assign bus.time_display = (state == VIEW) ? laps[lap_index] : tc;
  assign bus.counting = (state == RUN) || (state == PAUSE) || (state == VIEW && ret_pause);
  assign bus.paused = state == PAUSE;
  assign bus.viewing = state == VIEW;
  assign bus.lap_count = lap_count;
  assign bus.lap_index = lap_index;
  assign bus.lap_full = full;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: directed and random key sequences checked cycle by cycle against a behavioural model
module tb_stopwatch_lap;
  localparam int TD = 2, MT = 40, LD = 4, CW = 19, IW = 2;
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_VIEW} mst_t;
  logic clk = 1'b0, key3 = 1'b0;
  stopwatch_lap_if #(.CNT_W(CW), .IDX_W(IW)) bus ();
  stopwatch_lap #(.TICK_DIV(TD), .CNT_W(CW), .MAX_TIME(MT), .LAP_DEPTH(LD), .IDX_W(IW))
    dut (.clk(clk), .key3(key3), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  mst_t m_st;
  int m_time, m_runcyc, m_idx;
  int laps[$];
  bit m_ret_pause, m_ovf;
  bit h[3][4];
  task automatic chk(string tag, logic [31:0] got, int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_st = M_IDLE;
    m_time = 0;
    m_runcyc = 0;
    m_idx = 0;
    laps.delete();
    m_ret_pause = 0;
    m_ovf = 0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) h[i][j] = 1;
  endtask
  // a key acts three edges after the first edge that samples it low
  task automatic model_edge();
    bit [2:0] k, p;
    int old_time;
    bit tk;
    k = {bus.key2, bus.key1, bus.key0};
    for (int i = 0; i < 3; i++) begin
      p[i] = !h[i][2] && h[i][3];
      h[i][3] = h[i][2];
      h[i][2] = h[i][1];
      h[i][1] = h[i][0];
      h[i][0] = k[i];
    end
    if (p[2]) p[1:0] = 0;
    else if (p[1]) p[0] = 0;
    old_time = m_time;
    tk = 0;
    if (m_st == M_RUN) begin
      m_runcyc++;
      tk = (m_runcyc % TD) == 0;
    end
    if (tk) begin
      if (m_time == MT) begin
        m_time = 0;
        m_ovf = 1;
      end else m_time++;
    end
    case (m_st)
      M_IDLE:
        if (p[2]) begin
          m_st = M_RUN;
          m_runcyc = 0;
        end else if (p[0] && laps.size() > 0) begin
          m_st = M_VIEW;
          m_idx = 0;
          m_ret_pause = 0;
        end
      M_RUN:
        if (p[2]) m_st = M_PAUSE;
        else if (p[1] && laps.size() < LD) laps.push_back(old_time);
      M_PAUSE:
        if (p[2]) m_st = M_RUN;
        else if (p[0] && laps.size() > 0) begin
          m_st = M_VIEW;
          m_idx = 0;
          m_ret_pause = 1;
        end
      M_VIEW:
        if (p[2]) m_st = m_ret_pause ? M_PAUSE : M_IDLE;
        else if (p[0]) m_idx = (m_idx + 1) % laps.size();
    endcase
  endtask
  task automatic check_all();
    int ed;
    ed = (m_st == M_VIEW) ? laps[m_idx] : m_time;
    chk("time_display", bus.time_display, ed);
    chk("time_counter", bus.time_counter, m_time);
    chk("counting", bus.counting, int'(m_st == M_RUN || m_st == M_PAUSE || (m_st == M_VIEW && m_ret_pause)));
    chk("paused", bus.paused, int'(m_st == M_PAUSE));
    chk("viewing", bus.viewing, int'(m_st == M_VIEW));
    chk("lap_count", bus.lap_count, laps.size());
    chk("lap_index", bus.lap_index, m_idx);
    chk("lap_full", bus.lap_full, int'(laps.size() == LD));
    chk("overflow", bus.overflow, int'(m_ovf));
  endtask
  task automatic step();
    @(posedge clk);
    if (key3) model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic cyc(int n);
    repeat (n) step();
  endtask
  task automatic set_keys(bit [2:0] mask, bit v);
    if (mask[2]) bus.key2 = v;
    if (mask[1]) bus.key1 = v;
    if (mask[0]) bus.key0 = v;
  endtask
  task automatic press(bit [2:0] mask, int hold, int gap);
    set_keys(mask, 0);
    cyc(hold);
    set_keys(mask, 1);
    cyc(gap);
  endtask
  // reset asserted and released between clock edges to exercise the asynchronous path
  task automatic do_reset();
    #2 key3 = 1'b0;
    #1 model_reset();
    check_all();
    chk("reset_time_async", bus.time_counter, 0);
    #1 key3 = 1'b1;
  endtask
  initial begin
    bus.key2 = 1'b1;
    bus.key1 = 1'b1;
    bus.key0 = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();
    #3 key3 = 1'b1;
    cyc(2);
    press(3'b100, 2, 20);
    chk("run_counting", bus.counting, 1);
    chk("run_not_paused", bus.paused, 0);
    do_reset();
    chk("reset_counting", bus.counting, 0);
    press(3'b100, 1, 8);
    press(3'b010, 2, 6);
    press(3'b010, 1, 6);
    chk("two_laps", bus.lap_count, 2);
    press(3'b100, 2, 5);
    press(3'b001, 2, 5);
    chk("view_on", bus.viewing, 1);
    press(3'b001, 2, 5);
    press(3'b001, 2, 5);
    chk("view_wrap_index", bus.lap_index, 0);
    press(3'b100, 2, 5);
    chk("back_to_pause", bus.paused, 1);
    press(3'b100, 2, 4);
    press(3'b010, 1, 4);
    press(3'b010, 1, 4);
    press(3'b010, 1, 4);
    chk("laps_full_count", bus.lap_count, LD);
    chk("laps_full_flag", bus.lap_full, 1);
    cyc(100);
    chk("overflow_set", bus.overflow, 1);
    press(3'b100, 2, 6);
    press(3'b100, 2, 6);
    chk("overflow_sticky", bus.overflow, 1);
    press(3'b110, 2, 6);
    chk("prio_paused", bus.paused, 1);
    do_reset();
    press(3'b001, 2, 6);
    chk("idle_view_empty", bus.viewing, 0);
    press(3'b100, 50, 6);
    chk("hold_one_toggle", bus.paused, 0);
    set_keys(3'b100, 0);
    cyc(2);
    bus.key2 = 1'b1;
    #1 bus.key2 = 1'b0;
    cyc(5);
    set_keys(3'b100, 1);
    cyc(6);
    chk("glitch_one_toggle", bus.paused, 1);
    repeat (300) begin
      int r;
      bit [2:0] m;
      r = $urandom_range(0, 29);
      if (r == 0) do_reset();
      else begin
        m = (r < 4) ? 3'($urandom_range(1, 7)) : 3'(1 << $urandom_range(0, 2));
        press(m, $urandom_range(1, 5), $urandom_range(0, 6));
      end
    end
    cyc(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
